// File: rtl/eth_egress_chk_pkg.sv
// eth_egress_chk_pkg: shared state enum and default constants for the egress frame checker.
package eth_egress_chk_pkg;
  typedef enum logic {CHK_IDLE, CHK_IN_PKT} chk_state_e;
  localparam int MIN_FRAME_DEF = 64;
  localparam int MAX_FRAME_DEF = 1518;
  localparam int LEN_W = 16;
endpackage

// File: rtl/eth_sat_counter.sv
// eth_sat_counter: saturating up-counter with variable increment and synchronous clear.
module eth_sat_counter #(
  parameter int W = 32,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     cnt
);
  logic [W-1:0] base;
  logic [W:0]   sum;
  // Clear takes effect first so a same-cycle event still counts.
  always_comb begin
    base = clr ? '0 : cnt;
    sum = {1'b0, base} + (W+1)'(inc);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr || en) cnt <= !en ? '0 : sum[W] ? '1 : sum[W-1:0];
endmodule

// File: rtl/eth_egress_frame_checker.sv
// eth_egress_frame_checker: passive framing checker and saturating statistics on an egress stream.
// Optional mid-packet stall timeout is built when ETH_EGRESS_CHK_TIMEOUT_EN is defined.
module eth_egress_frame_checker
  import eth_egress_chk_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int MAX_FRAME = MAX_FRAME_DEF,
  parameter int MIN_FRAME = MIN_FRAME_DEF,
  parameter int CNT_W = 32,
  parameter int TIMEOUT = 1024,
  localparam int EMP_W = (DATA_W > 8) ? $clog2(DATA_W/8) : 1
) (
  input  logic              egress_clk,
  input  logic              egress_rst_n,
  input  logic [DATA_W-1:0] egress_data,
  input  logic              egress_valid,
  input  logic              egress_ready,
  input  logic              egress_sop,
  input  logic              egress_eop,
  input  logic              egress_error,
  input  logic [EMP_W-1:0]  egress_empty,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_pkt_cnt,
  output logic [CNT_W-1:0]  runt_cnt,
  output logic [CNT_W-1:0]  oversize_cnt,
  output logic [CNT_W-1:0]  viol_cnt,
  output logic [47:0]       byte_cnt,
  output logic [LEN_W-1:0]  last_len,
  output logic              last_len_vld,
  output logic              in_pkt,
  output logic              viol_pulse
);
  localparam logic [LEN_W:0] BEAT = (LEN_W+1)'(DATA_W/8);
  chk_state_e state, state_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [LEN_W:0] len_base, len_add, len_sum;
  logic xfer, done, viol, timeout, runt, oversize;
  logic unused;
  assign unused = ^{egress_data, 32'(TIMEOUT)};
  assign in_pkt = state == CHK_IN_PKT;
  always_comb begin
    xfer = egress_valid && egress_ready;
    len_base = (state == CHK_IDLE || egress_sop) ? '0 : {1'b0, len_q};
    len_add = egress_eop ? BEAT - (LEN_W+1)'(egress_empty) : BEAT;
    len_sum = len_base + len_add;
    len_nxt = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
    done = xfer && egress_eop && (egress_sop || state == CHK_IN_PKT);
    viol = timeout || (xfer && (state == CHK_IDLE ? !egress_sop : egress_sop));
    runt = len_nxt < LEN_W'(MIN_FRAME);
    oversize = len_nxt > LEN_W'(MAX_FRAME);
  end
  // A sop always (re)starts a frame; a non-sop beat only keeps IN_PKT alive until eop.
  always_comb begin
    state_nxt = state;
    if (xfer)
      state_nxt = egress_sop ? (egress_eop ? CHK_IDLE : CHK_IN_PKT)
                : (state == CHK_IN_PKT && !egress_eop) ? CHK_IN_PKT : CHK_IDLE;
    if (timeout) state_nxt = CHK_IDLE;
  end
  always_ff @(posedge egress_clk or negedge egress_rst_n)
    if (!egress_rst_n) state <= CHK_IDLE;
    else state <= state_nxt;
  always_ff @(posedge egress_clk or negedge egress_rst_n)
    if (!egress_rst_n) begin
      len_q <= '0;
      last_len <= '0;
      last_len_vld <= 1'b0;
      viol_pulse <= 1'b0;
    end else begin
      if (xfer) len_q <= len_nxt;
      if (done) last_len <= len_nxt;
      last_len_vld <= done;
      viol_pulse <= viol;
    end
`ifdef ETH_EGRESS_CHK_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT + 1);
  logic [ST_W-1:0] stall;
  assign timeout = in_pkt && !xfer && stall == ST_W'(TIMEOUT - 1);
  always_ff @(posedge egress_clk or negedge egress_rst_n)
    if (!egress_rst_n) stall <= '0;
    else stall <= (in_pkt && !xfer && !timeout) ? stall + 1'b1 : '0;
`else
  assign timeout = 1'b0;
`endif
  eth_sat_counter #(.W(CNT_W)) u_pkt (
    .clk(egress_clk), .rst_n(egress_rst_n), .clr(stats_clr), .en(done), .inc(1'b1), .cnt(pkt_cnt));
  eth_sat_counter #(.W(CNT_W)) u_err (
    .clk(egress_clk), .rst_n(egress_rst_n), .clr(stats_clr), .en(done && egress_error), .inc(1'b1),
    .cnt(err_pkt_cnt));
  eth_sat_counter #(.W(CNT_W)) u_runt (
    .clk(egress_clk), .rst_n(egress_rst_n), .clr(stats_clr), .en(done && runt), .inc(1'b1),
    .cnt(runt_cnt));
  eth_sat_counter #(.W(CNT_W)) u_over (
    .clk(egress_clk), .rst_n(egress_rst_n), .clr(stats_clr), .en(done && oversize), .inc(1'b1),
    .cnt(oversize_cnt));
  eth_sat_counter #(.W(CNT_W)) u_viol (
    .clk(egress_clk), .rst_n(egress_rst_n), .clr(stats_clr), .en(viol), .inc(1'b1), .cnt(viol_cnt));
  eth_sat_counter #(.W(48), .INC_W(LEN_W)) u_byte (
    .clk(egress_clk), .rst_n(egress_rst_n), .clr(stats_clr), .en(done), .inc(len_nxt), .cnt(byte_cnt));
endmodule

// File: tb/tb_eth_egress_frame_checker.sv
// tb_eth_egress_frame_checker: directed checks of framing, lengths, violations and saturation.
module tb_eth_egress_frame_checker;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [63:0] data = '0;
  logic valid = 0, ready = 1, sop = 0, eop = 0, error = 0, stats_clr = 0;
  logic [2:0] empty = '0;
  logic [31:0] pkt_cnt, err_pkt_cnt, runt_cnt, oversize_cnt, viol_cnt;
  logic [3:0] pkt_s, err_s, runt_s, over_s, viol_s;
  logic [47:0] byte_cnt, byte_s;
  logic [15:0] last_len, last_len_s;
  logic last_len_vld, in_pkt, viol_pulse, vld_s, in_pkt_s, viol_pulse_s;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  eth_egress_frame_checker #(.TIMEOUT(16)) dut (
    .egress_clk(clk), .egress_rst_n(rst_n), .egress_data(data), .egress_valid(valid),
    .egress_ready(ready), .egress_sop(sop), .egress_eop(eop), .egress_error(error),
    .egress_empty(empty), .stats_clr(stats_clr), .pkt_cnt(pkt_cnt), .err_pkt_cnt(err_pkt_cnt),
    .runt_cnt(runt_cnt), .oversize_cnt(oversize_cnt), .viol_cnt(viol_cnt), .byte_cnt(byte_cnt),
    .last_len(last_len), .last_len_vld(last_len_vld), .in_pkt(in_pkt), .viol_pulse(viol_pulse));

  // Narrow-counter copy on the same stream exposes saturation quickly.
  eth_egress_frame_checker #(.CNT_W(4), .TIMEOUT(16)) dut_s (
    .egress_clk(clk), .egress_rst_n(rst_n), .egress_data(data), .egress_valid(valid),
    .egress_ready(ready), .egress_sop(sop), .egress_eop(eop), .egress_error(error),
    .egress_empty(empty), .stats_clr(stats_clr), .pkt_cnt(pkt_s), .err_pkt_cnt(err_s),
    .runt_cnt(runt_s), .oversize_cnt(over_s), .viol_cnt(viol_s), .byte_cnt(byte_s),
    .last_len(last_len_s), .last_len_vld(vld_s), .in_pkt(in_pkt_s), .viol_pulse(viol_pulse_s));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic s, input logic e, input logic [2:0] emp, input logic er);
    valid = 1; sop = s; eop = e; empty = emp; error = er; data = {$urandom, $urandom};
    @(posedge clk); #1;
    valid = 0; sop = 0; eop = 0; empty = '0; error = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(2);
    chk("rst_pkt", pkt_cnt, 0);
    chk("rst_byte", byte_cnt, 0);
    chk("rst_len", last_len, 0);
    chk("rst_in_pkt", in_pkt, 0);
    chk("rst_viol", viol_cnt, 0);
    rst_n = 1;
    idle(1);
    ready = 0; valid = 1;
    idle(1);
    valid = 0; ready = 1;
    chk("noxfer_viol", viol_cnt, 0);
    chk("noxfer_pulse", viol_pulse, 0);
    beat(1, 0, 0, 0);
    chk("sop_in_pkt", in_pkt, 1);
    repeat (6) beat(0, 0, 0, 0);
    chk("mid_pkt", pkt_cnt, 0);
    beat(0, 1, 4, 0);
    chk("f60_pkt", pkt_cnt, 1);
    chk("f60_len", last_len, 60);
    chk("f60_vld", last_len_vld, 1);
    chk("f60_runt", runt_cnt, 1);
    chk("f60_byte", byte_cnt, 60);
    chk("f60_in_pkt", in_pkt, 0);
    idle(1);
    chk("vld_pulse", last_len_vld, 0);
    beat(1, 0, 0, 0);
    repeat (189) beat(0, 0, 0, 0);
    beat(0, 1, 2, 0);
    chk("big_len", last_len, 1526);
    chk("big_over", oversize_cnt, 1);
    chk("big_runt", runt_cnt, 1);
    chk("big_byte", byte_cnt, 1586);
    beat(1, 0, 0, 0);
    beat(0, 0, 0, 0);
    beat(1, 0, 0, 0);
    chk("resop_pulse", viol_pulse, 1);
    chk("resop_in_pkt", in_pkt, 1);
    beat(0, 1, 0, 0);
    chk("resop_viol", viol_cnt, 1);
    chk("resop_pkt", pkt_cnt, 3);
    chk("resop_len", last_len, 16);
    chk("resop_pulse_off", viol_pulse, 0);
    stats_clr = 1;
    idle(1);
    stats_clr = 0;
    chk("clr_pkt", pkt_cnt, 0);
    chk("clr_byte", byte_cnt, 0);
    beat(0, 0, 0, 0);
    chk("orphan_pulse", viol_pulse, 1);
    chk("orphan_in_pkt", in_pkt, 0);
    repeat (64) beat(1, 1, 0, 1);
    chk("b2b_viol", viol_cnt, 1);
    chk("b2b_pkt", pkt_cnt, 64);
    chk("b2b_err", err_pkt_cnt, 64);
    chk("b2b_runt", runt_cnt, 64);
    chk("b2b_byte", byte_cnt, 512);
    chk("b2b_len", last_len, 8);
    chk("sat_pkt", pkt_s, 15);
    chk("sat_err", err_s, 15);
    chk("sat_viol", viol_s, 1);
    beat(1, 1, 0, 0);
    chk("sat_hold", pkt_s, 15);
    stats_clr = 1;
    beat(1, 1, 3, 0);
    stats_clr = 0;
    chk("clr_evt_pkt", pkt_cnt, 1);
    chk("clr_evt_byte", byte_cnt, 5);
    chk("clr_evt_err", err_pkt_cnt, 0);
    chk("clr_evt_small", pkt_s, 1);
    beat(1, 0, 0, 0);
    idle(16);
`ifdef ETH_EGRESS_CHK_TIMEOUT_EN
    chk("tmo_pulse", viol_pulse, 1);
    chk("tmo_in_pkt", in_pkt, 0);
    chk("tmo_viol", viol_cnt, 1);
`else
    chk("stall_pulse", viol_pulse, 0);
    chk("stall_in_pkt", in_pkt, 1);
    chk("stall_viol", viol_cnt, 0);
`endif
    beat(1, 0, 0, 0);
    beat(0, 0, 0, 0);
    rst_n = 0;
    #2;
    chk("mrst_pkt", pkt_cnt, 0);
    chk("mrst_viol", viol_cnt, 0);
    chk("mrst_byte", byte_cnt, 0);
    chk("mrst_len", last_len, 0);
    chk("mrst_in_pkt", in_pkt, 0);
    chk("mrst_pulse", viol_pulse, 0);
    rst_n = 1;
    idle(1);
    beat(1, 0, 0, 0);
    beat(0, 1, 0, 1);
    chk("post_pkt", pkt_cnt, 1);
    chk("post_len", last_len, 16);
    chk("post_err", err_pkt_cnt, 1);
    chk("post_viol", viol_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
